// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer
// Two-entry skid buffer placed between two pipeline stages. It carries PC,
// instruction, immediate Data and INT fields. Upstream may issue one extra
// beat after downstream stalls; that beat lands in the skid slot.
// All state changes on the falling edge of clk.
//
// Handshake: a beat is accepted on a falling edge when in_valid & in_ready,
// and the head is consumed on the same edge when out_valid & out_ready.
// in_ready depends only on registered state, never on out_ready, so there is
// no combinational ready path through the buffer. Once a beat is offered,
// upstream holds it until it is accepted. Downstream reads the head fields
// whenever out_valid is high.
module pipe_skid_buffer #(
    parameter int PC_WIDTH       = 32,
    parameter int INSTR_WIDTH    = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int FLUSH_KEEPS_PC = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_WIDTH-1:0]    PC_in,
    input  logic [INSTR_WIDTH-1:0] instruction_in,
    input  logic [DATA_WIDTH-1:0]  Data_in,
    input  logic                   INT_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    PC_out,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic [DATA_WIDTH-1:0]  Data_out,
    output logic                   INT_out,
    input  logic                   flush,
    output logic [1:0]             occupancy,
    output logic [1:0]             dbg_state,
    output logic                   dbg_pending_int
);

    // The state encoding equals the number of valid entries, so occupancy is
    // the state register itself.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Registered state.
    logic [1:0]             r_state;
    logic [PC_WIDTH-1:0]    r_head_pc;
    logic [INSTR_WIDTH-1:0] r_head_instr;
    logic [DATA_WIDTH-1:0]  r_head_data;
    logic                   r_head_int;
    logic [PC_WIDTH-1:0]    r_skid_pc;
    logic [INSTR_WIDTH-1:0] r_skid_instr;
    logic [DATA_WIDTH-1:0]  r_skid_data;
    logic                   r_skid_int;
    logic                   r_pending_int;

    // Handshake terms and next-state values.
    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_accept;
    logic                   w_consume;
    logic                   w_in_int;
    logic                   w_head_int_live;
    logic                   w_skid_int_live;
    logic [1:0]             w_state_nxt;
    logic [PC_WIDTH-1:0]    w_head_pc_nxt;
    logic [INSTR_WIDTH-1:0] w_head_instr_nxt;
    logic [DATA_WIDTH-1:0]  w_head_data_nxt;
    logic                   w_head_int_nxt;
    logic [PC_WIDTH-1:0]    w_skid_pc_nxt;
    logic [INSTR_WIDTH-1:0] w_skid_instr_nxt;
    logic [DATA_WIDTH-1:0]  w_skid_data_nxt;
    logic                   w_skid_int_nxt;
    logic                   w_pending_nxt;

    assign w_in_ready  = (r_state != ST_FULL);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = in_valid & w_in_ready;
    assign w_consume   = w_out_valid & out_ready;

    // An interrupt left over from a flushed beat rides on the next accepted beat.
    assign w_in_int = INT_in | r_pending_int;

    // The skid slot keeps stale contents after FULL->ONE, so its INT only
    // counts while the buffer is FULL.
    assign w_head_int_live = w_out_valid & r_head_int;
    assign w_skid_int_live = (r_state == ST_FULL) & r_skid_int;

    // Next-state logic: flush overrides the handshake, and reset overrides
    // both in the register block.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_pc_nxt    = r_head_pc;
        w_head_instr_nxt = r_head_instr;
        w_head_data_nxt  = r_head_data;
        w_head_int_nxt   = r_head_int;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_data_nxt  = r_skid_data;
        w_skid_int_nxt   = r_skid_int;
        w_pending_nxt    = r_pending_int;

        if (flush) begin
            // Drop every entry, including a beat accepted on this edge.
            // The interrupts of those entries are kept in pending_int.
            w_state_nxt      = ST_EMPTY;
            w_head_pc_nxt    = (FLUSH_KEEPS_PC != 0) ? r_head_pc : '0;
            w_skid_pc_nxt    = (FLUSH_KEEPS_PC != 0) ? r_skid_pc : '0;
            w_head_instr_nxt = '0;
            w_head_data_nxt  = '0;
            w_head_int_nxt   = 1'b0;
            w_skid_instr_nxt = '0;
            w_skid_data_nxt  = '0;
            w_skid_int_nxt   = 1'b0;
            w_pending_nxt    = r_pending_int | w_head_int_live | w_skid_int_live
                             | (w_accept & INT_in);
        end else begin
            // The accepted beat has absorbed the pending interrupt.
            if (w_accept) begin
                w_pending_nxt = 1'b0;
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_head_pc_nxt    = PC_in;
                        w_head_instr_nxt = instruction_in;
                        w_head_data_nxt  = Data_in;
                        w_head_int_nxt   = w_in_int;
                        w_state_nxt      = ST_ONE;
                    end
                end

                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_head_pc_nxt    = PC_in;
                        w_head_instr_nxt = instruction_in;
                        w_head_data_nxt  = Data_in;
                        w_head_int_nxt   = w_in_int;
                    end else if (w_accept) begin
                        w_skid_pc_nxt    = PC_in;
                        w_skid_instr_nxt = instruction_in;
                        w_skid_data_nxt  = Data_in;
                        w_skid_int_nxt   = w_in_int;
                        w_state_nxt      = ST_FULL;
                    end else if (w_consume) begin
                        // Head fields stay put so PC_out shows the last head PC.
                        w_state_nxt = ST_EMPTY;
                    end
                end

                ST_FULL: begin
                    // in_ready is low here, so only a consume can happen.
                    if (w_consume) begin
                        w_head_pc_nxt    = r_skid_pc;
                        w_head_instr_nxt = r_skid_instr;
                        w_head_data_nxt  = r_skid_data;
                        w_head_int_nxt   = r_skid_int;
                        w_state_nxt      = ST_ONE;
                    end
                end

                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Register update on the falling edge, with synchronous reset taking priority.
    always_ff @(negedge clk) begin
        if (reset) begin
            r_state       <= ST_EMPTY;
            r_head_pc     <= '0;
            r_head_instr  <= '0;
            r_head_data   <= '0;
            r_head_int    <= 1'b0;
            r_skid_pc     <= '0;
            r_skid_instr  <= '0;
            r_skid_data   <= '0;
            r_skid_int    <= 1'b0;
            r_pending_int <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_head_pc     <= w_head_pc_nxt;
            r_head_instr  <= w_head_instr_nxt;
            r_head_data   <= w_head_data_nxt;
            r_head_int    <= w_head_int_nxt;
            r_skid_pc     <= w_skid_pc_nxt;
            r_skid_instr  <= w_skid_instr_nxt;
            r_skid_data   <= w_skid_data_nxt;
            r_skid_int    <= w_skid_int_nxt;
            r_pending_int <= w_pending_nxt;
        end
    end

    // Outputs come only from registers. Payload fields read as zero (NOP)
    // when the head is not valid.
    assign in_ready        = w_in_ready;
    assign out_valid       = w_out_valid;
    assign occupancy       = r_state;
    assign PC_out          = r_head_pc;
    assign instruction_out = w_out_valid ? r_head_instr : '0;
    assign Data_out        = w_out_valid ? r_head_data : '0;
    assign INT_out         = w_out_valid & r_head_int;
    assign dbg_state       = r_state;
    assign dbg_pending_int = r_pending_int;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer. Instance a uses the default widths and keeps
// the PC on flush. Instance b has a 16-bit PC, 32-bit Data, and clears the
// PC on flush. Both instances share the control inputs and follow the same
// state sequence.
module tb_pipe_skid_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready, int_in;
  logic [31:0] pc_in;
  logic [15:0] instr_in, data_in;
  logic [15:0] pc_in_b;
  logic [31:0] data_in_b;

  assign pc_in_b   = pc_in[15:0];
  assign data_in_b = {16'hC0DE, data_in};

  logic        ir_a, ov_a, int_a, pend_a;
  logic [31:0] pc_a;
  logic [15:0] instr_a, data_a;
  logic [1:0]  occ_a, st_a;

  logic        ir_b, ov_b, int_b, pend_b;
  logic [15:0] pc_b;
  logic [15:0] instr_b;
  logic [31:0] data_b;
  logic [1:0]  occ_b, st_b;

  pipe_skid_buffer #(
    .PC_WIDTH(32), .INSTR_WIDTH(16), .DATA_WIDTH(16), .FLUSH_KEEPS_PC(1)
  ) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_a),
    .PC_in(pc_in), .instruction_in(instr_in), .Data_in(data_in), .INT_in(int_in),
    .out_valid(ov_a), .out_ready(out_ready), .PC_out(pc_a),
    .instruction_out(instr_a), .Data_out(data_a), .INT_out(int_a),
    .flush(flush), .occupancy(occ_a), .dbg_state(st_a), .dbg_pending_int(pend_a)
  );

  pipe_skid_buffer #(
    .PC_WIDTH(16), .INSTR_WIDTH(16), .DATA_WIDTH(32), .FLUSH_KEEPS_PC(0)
  ) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir_b),
    .PC_in(pc_in_b), .instruction_in(instr_in), .Data_in(data_in_b), .INT_in(int_in),
    .out_valid(ov_b), .out_ready(out_ready), .PC_out(pc_b),
    .instruction_out(instr_b), .Data_out(data_b), .INT_out(int_b),
    .flush(flush), .occupancy(occ_b), .dbg_state(st_b), .dbg_pending_int(pend_b)
  );

  int checks = 0;
  int failures = 0;

  logic [68:0] obs_a, obs_b, exp_a, exp_b;
  assign obs_a = {ov_a, ir_a, occ_a, int_a, instr_a, data_a, pc_a};
  assign obs_b = {ov_b, ir_b, occ_b, int_b, instr_b, data_b, pc_b};

  function automatic logic [68:0] pack_a(input logic ov, input logic ir, input logic [1:0] occ,
                                         input logic iv, input logic [15:0] ins,
                                         input logic [15:0] d, input logic [31:0] pc);
    return {ov, ir, occ, iv, ins, d, pc};
  endfunction

  function automatic logic [68:0] pack_b(input logic ov, input logic ir, input logic [1:0] occ,
                                         input logic iv, input logic [15:0] ins,
                                         input logic [31:0] d, input logic [15:0] pc);
    return {ov, ir, occ, iv, ins, d, pc};
  endfunction

  // ---- driver tasks ----
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [31:0] pc, input logic [15:0] ins,
                            input logic [15:0] d, input logic iv);
    in_valid = 1'b1;
    pc_in    = pc;
    instr_in = ins;
    data_in  = d;
    int_in   = iv;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    pc_in    = 32'h0;
    instr_in = 16'h0;
    data_in  = 16'h0;
    int_in   = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive_beat(32'h1234, 16'h5555, 16'h6666, 1'b1);
    tick();
    tick();
    exp_a = pack_a(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0, 32'h0);
    exp_b = pack_b(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 32'h0, 16'h0);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL reset_a got=%h exp=%h", obs_a, exp_a); end
    checks++; if (obs_b !== exp_b) begin failures++; $display("FAIL reset_b got=%h exp=%h", obs_b, exp_b); end
    checks++;
    if ({st_a, st_b, pend_a, pend_b} !== 6'b0) begin
      failures++; $display("FAIL reset_state got=%b exp=000000", {st_a, st_b, pend_a, pend_b});
    end
    reset = 1'b0;
    drive_idle();
    tick();
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL reset_release_a got=%h exp=%h", obs_a, exp_a); end
    checks++; if (obs_b !== exp_b) begin failures++; $display("FAIL reset_release_b got=%h exp=%h", obs_b, exp_b); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_beat(32'h10 + 32'(k), 16'h0110 + 16'(k), 16'h1000 + 16'(k), 1'b0);
      tick();
      exp_a = pack_a(1'b1, 1'b1, 2'd1, 1'b0, 16'h0110 + 16'(k), 16'h1000 + 16'(k), 32'h10 + 32'(k));
      exp_b = pack_b(1'b1, 1'b1, 2'd1, 1'b0, 16'h0110 + 16'(k), {16'hC0DE, 16'h1000 + 16'(k)},
                     16'h10 + 16'(k));
      checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL stream_a%0d got=%h exp=%h", k, obs_a, exp_a); end
      checks++; if (obs_b !== exp_b) begin failures++; $display("FAIL stream_b%0d got=%h exp=%h", k, obs_b, exp_b); end
    end
    drive_idle();
    tick();
    exp_a = pack_a(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0, 32'h12);
    exp_b = pack_b(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 32'h0, 16'h12);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL stream_drain_a got=%h exp=%h", obs_a, exp_a); end
    checks++; if (obs_b !== exp_b) begin failures++; $display("FAIL stream_drain_b got=%h exp=%h", obs_b, exp_b); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    drive_beat(32'h20, 16'h0120, 16'h2000, 1'b0);
    tick();
    exp_a = pack_a(1'b1, 1'b1, 2'd1, 1'b0, 16'h0120, 16'h2000, 32'h20);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL skid_one_a got=%h exp=%h", obs_a, exp_a); end
    drive_beat(32'h21, 16'h0121, 16'h2001, 1'b0);
    tick();
    exp_a = pack_a(1'b1, 1'b0, 2'd2, 1'b0, 16'h0120, 16'h2000, 32'h20);
    exp_b = pack_b(1'b1, 1'b0, 2'd2, 1'b0, 16'h0120, {16'hC0DE, 16'h2000}, 16'h20);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL skid_full_a got=%h exp=%h", obs_a, exp_a); end
    checks++; if (obs_b !== exp_b) begin failures++; $display("FAIL skid_full_b got=%h exp=%h", obs_b, exp_b); end
    // A beat offered while FULL must not be taken, and the head must hold.
    drive_beat(32'h22, 16'h0122, 16'h2002, 1'b1);
    tick();
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL skid_hold_a got=%h exp=%h", obs_a, exp_a); end
    drive_idle();
    out_ready = 1'b1;
    tick();
    exp_a = pack_a(1'b1, 1'b1, 2'd1, 1'b0, 16'h0121, 16'h2001, 32'h21);
    exp_b = pack_b(1'b1, 1'b1, 2'd1, 1'b0, 16'h0121, {16'hC0DE, 16'h2001}, 16'h21);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL skid_pop_a got=%h exp=%h", obs_a, exp_a); end
    checks++; if (obs_b !== exp_b) begin failures++; $display("FAIL skid_pop_b got=%h exp=%h", obs_b, exp_b); end
    tick();
    exp_a = pack_a(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0, 32'h21);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL skid_empty_a got=%h exp=%h", obs_a, exp_a); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive_beat(32'h30, 16'hABCD, 16'h3000, 1'b0);
    tick();
    drive_beat(32'h31, 16'h0131, 16'h3001, 1'b0);
    tick();
    exp_a = pack_a(1'b1, 1'b0, 2'd2, 1'b0, 16'hABCD, 16'h3000, 32'h30);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL flush_pre_a got=%h exp=%h", obs_a, exp_a); end
    drive_beat(32'h32, 16'h0132, 16'h3002, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_idle();
    exp_a = pack_a(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0, 32'h30);
    exp_b = pack_b(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 32'h0, 16'h0);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL flush_a got=%h exp=%h", obs_a, exp_a); end
    checks++; if (obs_b !== exp_b) begin failures++; $display("FAIL flush_b got=%h exp=%h", obs_b, exp_b); end
    checks++; if ({pend_a, pend_b} !== 2'b00) begin failures++; $display("FAIL flush_pend got=%b exp=00", {pend_a, pend_b}); end
    tick();
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL flush_after_a got=%h exp=%h", obs_a, exp_a); end
  endtask

  task automatic test_sticky_int();
    out_ready = 1'b0;
    drive_beat(32'h40, 16'h0140, 16'h4000, 1'b0);
    tick();
    drive_beat(32'h41, 16'h0141, 16'h4001, 1'b1);
    tick();
    exp_a = pack_a(1'b1, 1'b0, 2'd2, 1'b0, 16'h0140, 16'h4000, 32'h40);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL sticky_full_a got=%h exp=%h", obs_a, exp_a); end
    drive_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({pend_a, pend_b} !== 2'b11) begin failures++; $display("FAIL sticky_pend_skid got=%b exp=11", {pend_a, pend_b}); end
    exp_b = pack_b(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 32'h0, 16'h0);
    checks++; if (obs_b !== exp_b) begin failures++; $display("FAIL sticky_flush_b got=%h exp=%h", obs_b, exp_b); end
    drive_beat(32'h42, 16'h0142, 16'h4002, 1'b0);
    tick();
    exp_a = pack_a(1'b1, 1'b1, 2'd1, 1'b1, 16'h0142, 16'h4002, 32'h42);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL sticky_carry_a got=%h exp=%h", obs_a, exp_a); end
    checks++; if ({pend_a, pend_b} !== 2'b00) begin failures++; $display("FAIL sticky_clear got=%b exp=00", {pend_a, pend_b}); end
    out_ready = 1'b1;
    drive_beat(32'h43, 16'h0143, 16'h4003, 1'b0);
    tick();
    exp_a = pack_a(1'b1, 1'b1, 2'd1, 1'b0, 16'h0143, 16'h4003, 32'h43);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL sticky_next_a got=%h exp=%h", obs_a, exp_a); end
    // Flush with a same-edge accepted beat carrying INT.
    out_ready = 1'b0;
    drive_beat(32'h44, 16'h0144, 16'h4004, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_idle();
    exp_a = pack_a(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0, 32'h43);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL sticky_flush_in_a got=%h exp=%h", obs_a, exp_a); end
    checks++; if ({pend_a, pend_b} !== 2'b11) begin failures++; $display("FAIL sticky_pend_in got=%b exp=11", {pend_a, pend_b}); end
    tick();
    checks++; if ({pend_a, pend_b} !== 2'b11) begin failures++; $display("FAIL sticky_pend_persist got=%b exp=11", {pend_a, pend_b}); end
    drive_beat(32'h45, 16'h0145, 16'h4005, 1'b0);
    tick();
    exp_b = pack_b(1'b1, 1'b1, 2'd1, 1'b1, 16'h0145, {16'hC0DE, 16'h4005}, 16'h45);
    checks++; if (obs_b !== exp_b) begin failures++; $display("FAIL sticky_carry2_b got=%h exp=%h", obs_b, exp_b); end
    drive_idle();
    out_ready = 1'b1;
    tick();
    exp_a = pack_a(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0, 32'h45);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL sticky_drain_a got=%h exp=%h", obs_a, exp_a); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    drive_beat(32'h50, 16'h0150, 16'h5000, 1'b1);
    tick();
    drive_beat(32'h51, 16'h0151, 16'h5001, 1'b1);
    tick();
    exp_a = pack_a(1'b1, 1'b0, 2'd2, 1'b1, 16'h0150, 16'h5000, 32'h50);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL simul_pre_a got=%h exp=%h", obs_a, exp_a); end
    drive_beat(32'h52, 16'h0152, 16'h5002, 1'b1);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    exp_a = pack_a(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 16'h0, 32'h0);
    exp_b = pack_b(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 32'h0, 16'h0);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL simul_a got=%h exp=%h", obs_a, exp_a); end
    checks++; if (obs_b !== exp_b) begin failures++; $display("FAIL simul_b got=%h exp=%h", obs_b, exp_b); end
    checks++;
    if ({st_a, st_b, pend_a, pend_b} !== 6'b0) begin
      failures++; $display("FAIL simul_state got=%b exp=000000", {st_a, st_b, pend_a, pend_b});
    end
    reset = 1'b0;
    flush = 1'b0;
    drive_beat(32'h53, 16'h0153, 16'h5003, 1'b0);
    tick();
    exp_a = pack_a(1'b1, 1'b1, 2'd1, 1'b0, 16'h0153, 16'h5003, 32'h53);
    exp_b = pack_b(1'b1, 1'b1, 2'd1, 1'b0, 16'h0153, {16'hC0DE, 16'h5003}, 16'h53);
    checks++; if (obs_a !== exp_a) begin failures++; $display("FAIL simul_after_a got=%h exp=%h", obs_a, exp_a); end
    checks++; if (obs_b !== exp_b) begin failures++; $display("FAIL simul_after_b got=%h exp=%h", obs_b, exp_b); end
    drive_idle();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive_idle();
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_sticky_int();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_skid_buffer.md
Name: pipe_skid_buffer

Overview:
Parametrised successor to the fixed IF/ID-style stage register: a two-entry skid buffer sitting between any two pipeline stages (IF/ID, ID/EX, ...). It carries PC, instruction, immediate Data and INT fields under a valid/ready handshake, so upstream can keep issuing for one cycle after downstream stalls. It supports synchronous flush, NOP-forcing and sticky interrupt carry across flushes.

Parameters:
PC_WIDTH, 32, width of PC field
INSTR_WIDTH, 16, width of instruction field
DATA_WIDTH, 16, width of immediate Data field
FLUSH_KEEPS_PC, 1, 1: PC_out retains last value on flush; 0: PC_out cleared on flush

Ports:
clk  in  1  clock; all state updates on falling edge of clk (pipeline buffer convention)
reset  in  1  synchronous, active-high; sampled on the falling edge of clk
in_valid  in  1  upstream beat present
in_ready  out  1  buffer can accept a beat
PC_in  in  PC_WIDTH  PC from upstream stage
instruction_in  in  INSTR_WIDTH  instruction from upstream
Data_in  in  DATA_WIDTH  immediate from upstream
INT_in  in  1  interrupt request tagged to beat
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes head (inverse of stall)
PC_out  out  PC_WIDTH  head PC
instruction_out  out  INSTR_WIDTH  head instruction; 0 (NOP) when !out_valid
Data_out  out  DATA_WIDTH  head immediate; 0 when !out_valid
INT_out  out  1  head INT; 0 when !out_valid
flush  in  1  synchronous flush
occupancy  out  2  number of valid entries, 0..2

Behaviour:
- Storage: head slot (drives outputs) and skid slot. State EMPTY / ONE / FULL; occupancy = 0/1/2.
- in_ready = (state != FULL); combinational from registered state only, never from out_ready.
- out_valid = (state != EMPTY).
- Accept = in_valid & in_ready. Consume = out_valid & out_ready. Both evaluated at the same clk edge.
- EMPTY: accept -> head <= input, go to ONE.
- ONE:
  - accept & consume -> head <= input, stay ONE.
  - accept & !consume -> skid <= input, go to FULL.
  - !accept & consume -> EMPTY.
  - otherwise hold.
- FULL:
  - consume -> head <= skid, go to ONE.
  - otherwise hold all fields bit-exact.
- Priority: reset > flush > handshake.
- Reset (sync):
  - state EMPTY, both slots and pending_int cleared.
  - Outputs next cycle: PC_out=0, instruction_out=0, Data_out=0, INT_out=0, out_valid=0, in_ready=1, occupancy=0.
  - Reset mid-FULL discards both entries; no partial transfer.
- Flush (sync, next edge):
  - State goes EMPTY and both entries are invalidated.
  - A beat accepted on the flush edge is discarded.
  - instruction/Data slots cleared to 0.
  - PC slot retained when FLUSH_KEEPS_PC=1, cleared to 0 when FLUSH_KEEPS_PC=0.
  - INT is never lost: pending_int <= OR of INT of every discarded entry (head, skid, and same-edge input beat with INT_in=1).
- Sticky INT: on the next accepted beat, its stored INT = INT_in | pending_int, and pending_int clears. pending_int persists through stalls; only reset clears it otherwise.
- When !out_valid:
  - instruction_out/Data_out/INT_out forced 0.
  - PC_out shows the last head PC, or 0 after reset, or per FLUSH_KEEPS_PC after flush.
- No combinational path from in_* to out_*. Latency is 1 edge from accept to out_valid when EMPTY.
- Field widths are independent; no truncation or extension inside the block.

Test Plan:
- Reset sequencing:
  - Stimulus: reset=1 for 2 edges while in_valid=1, PC_in=0x1234.
  - Required: out_valid=0, all outputs 0, occupancy=0.
  - Stimulus: then release reset.
  - Required: in_ready=1.
- Streaming:
  - Stimulus: out_ready=1, beats PC=0x10,0x11,0x12 on consecutive edges.
  - Required: each appears on PC_out one edge after accept; occupancy stays 1; in_ready never drops.
- Skid:
  - Stimulus: in ONE with head PC=0x20, drop out_ready, present PC=0x21.
  - Required: occupancy=2, in_ready=0, PC_out holds 0x20.
  - Stimulus: raise out_ready.
  - Required: PC_out=0x21 next edge, then EMPTY.
- Flush:
  - Stimulus: flush from FULL (head PC=0x30 instr=0xABCD, skid PC=0x31) with concurrent accept PC=0x32.
  - Required: out_valid=0, instruction_out=0, Data_out=0, occupancy=0; PC_out=0x30 (FLUSH_KEEPS_PC=1) or 0 (=0).
- Sticky INT:
  - Stimulus: flush with skid INT=1, then accept beat with INT_in=0.
  - Required: that beat shows INT_out=1.
  - Stimulus: accept the following beat.
  - Required: INT_out=0.
- Simultaneous events:
  - Stimulus: reset and flush high together in FULL.
  - Required: reset wins, with all outputs 0 and pending_int=0.
  - Stimulus: repeat with PC_WIDTH=16, DATA_WIDTH=32.
  - Required: same results.
